// File: rtl/feedforward_mul_pkg.sv
// Shared widths, limits and helpers for the feedforward multiply/accumulate datapath.
package feedforward_mul_pkg;

    localparam int MIN_STAGES = 2;
    localparam int LIM_W      = 128;

    function automatic int ext_w(input int w);
        return w + 1;
    endfunction

    function automatic int full_w(input int aw, input int bw);
        return aw + bw + 2;
    endfunction

    function automatic logic signed [LIM_W-1:0] smax(input int w);
        logic signed [LIM_W-1:0] one;
        one = LIM_W'(1);
        return (one <<< (w - 1)) - one;
    endfunction

    function automatic logic signed [LIM_W-1:0] smin(input int w);
        logic signed [LIM_W-1:0] one;
        one = LIM_W'(1);
        return -(one <<< (w - 1));
    endfunction

endpackage

// File: rtl/feedforward_sat_acc.sv
// Saturating signed accumulator with clear and a sticky saturation flag.
module feedforward_sat_acc
    import feedforward_mul_pkg::*;
#(
    parameter int P_W   = 39,
    parameter int ACC_W = 48
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic                    clr,
    input  logic signed [P_W-1:0]   p,
    output logic signed [ACC_W-1:0] acc,
    output logic                    acc_valid,
    output logic                    acc_sat
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(smax(ACC_W));
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(smin(ACC_W));

    logic signed [ACC_W-1:0] p_ext;
    logic        [ACC_W:0]   sum;
    logic                    pos_ovf;
    logic                    neg_ovf;
    logic signed [ACC_W-1:0] sum_sat;

    assign p_ext   = ACC_W'(p);
    assign sum     = {acc[ACC_W-1], acc} + {p_ext[ACC_W-1], p_ext};
    assign pos_ovf = ~sum[ACC_W] &  sum[ACC_W-1];
    assign neg_ovf =  sum[ACC_W] & ~sum[ACC_W-1];

    // Clamp the one-bit-wider sum back into the accumulator range.
    always_comb begin
        sum_sat = sum[ACC_W-1:0];
        if (pos_ovf) begin
            sum_sat = ACC_MAX;
        end else if (neg_ovf) begin
            sum_sat = ACC_MIN;
        end
    end

    // Load on a clear-tagged product, otherwise add with saturation; the flag is sticky until cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            acc_valid <= 1'b0;
            acc_sat   <= 1'b0;
        end else if (ce) begin
            acc_valid <= in_valid;
            if (in_valid) begin
                if (clr) begin
                    acc     <= p_ext;
                    acc_sat <= 1'b0;
                end else begin
                    acc <= sum_sat;
                    if (pos_ovf || neg_ovf) begin
                        acc_sat <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/feedforward_mul_pipe_mac.sv
// Parametrised pipelined multiplier with truncation overflow flag and saturating accumulator.
module feedforward_mul_pipe_mac
    import feedforward_mul_pkg::*;
#(
    parameter int A_W      = 7,
    parameter int B_W      = 32,
    parameter int A_SIGNED = 0,
    parameter int B_SIGNED = 1,
    parameter int P_W      = 39,
    parameter int STAGES   = 3,
    parameter int ACC_W    = 48
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic [A_W-1:0]          a,
    input  logic [B_W-1:0]          b,
    input  logic                    acc_clr,
    output logic signed [P_W-1:0]   p,
    output logic                    p_valid,
    output logic                    p_ovf,
    output logic signed [ACC_W-1:0] acc,
    output logic                    acc_valid,
    output logic                    acc_sat
);

    localparam int AX_W = ext_w(A_W);
    localparam int BX_W = ext_w(B_W);
    localparam int F    = full_w(A_W, B_W);

    if (STAGES < MIN_STAGES) begin : g_chk_stages
        $error("feedforward_mul_pipe_mac: STAGES must be at least %0d", MIN_STAGES);
    end
    if (ACC_W < P_W) begin : g_chk_acc
        $error("feedforward_mul_pipe_mac: ACC_W must be >= P_W");
    end
    if (P_W > F || P_W < 1) begin : g_chk_pw
        $error("feedforward_mul_pipe_mac: P_W must be in 1..A_W+B_W+2");
    end

    logic [A_W-1:0]         s1_a;
    logic [B_W-1:0]         s1_b;
    logic                   s1_v;
    logic                   s1_clr;
    logic signed [AX_W-1:0] a_x;
    logic signed [BX_W-1:0] b_x;
    logic signed [F-1:0]    prod_full;

    // Operand capture; data loads on every ce cycle and the valid bit marks real slots.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_a   <= '0;
            s1_b   <= '0;
            s1_v   <= 1'b0;
            s1_clr <= 1'b0;
        end else if (ce) begin
            s1_a   <= a;
            s1_b   <= b;
            s1_v   <= in_valid;
            s1_clr <= acc_clr & in_valid;
        end
    end

    assign a_x       = (A_SIGNED != 0) ? {s1_a[A_W-1], s1_a} : {1'b0, s1_a};
    assign b_x       = (B_SIGNED != 0) ? {s1_b[B_W-1], s1_b} : {1'b0, s1_b};
    assign prod_full = F'(a_x) * F'(b_x);

    for (genvar k = 2; k <= STAGES; k++) begin : g_stage
        logic signed [F-1:0] nxt_prod;
        logic                nxt_v;
        logic                nxt_clr;
        logic signed [F-1:0] q_prod;
        logic                q_v;
        logic                q_clr;

        if (k == 2) begin : g_mul
            assign nxt_prod = prod_full;
            assign nxt_v    = s1_v;
            assign nxt_clr  = s1_clr;
        end else begin : g_dly
            assign nxt_prod = g_stage[k-1].q_prod;
            assign nxt_v    = g_stage[k-1].q_v;
            assign nxt_clr  = g_stage[k-1].q_clr;
        end

        // Product/delay stage; the last stage only takes valid data so the outputs hold between products.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                q_prod <= '0;
                q_v    <= 1'b0;
                q_clr  <= 1'b0;
            end else if (ce) begin
                q_v   <= nxt_v;
                q_clr <= nxt_clr & nxt_v;
                if ((k < STAGES) || nxt_v) begin
                    q_prod <= nxt_prod;
                end
            end
        end
    end

    logic signed [F-1:0] last_prod;
    logic                last_clr;

    assign last_prod = g_stage[STAGES].q_prod;
    assign last_clr  = g_stage[STAGES].q_clr;
    assign p_valid   = g_stage[STAGES].q_v;
    assign p         = last_prod[P_W-1:0];

    if (P_W < F) begin : g_ovf
        assign p_ovf = (last_prod[F-1:P_W] != {(F-P_W){last_prod[P_W-1]}});
    end else begin : g_no_ovf
        assign p_ovf = 1'b0;
    end

    feedforward_sat_acc #(
        .P_W   (P_W),
        .ACC_W (ACC_W)
    ) u_acc (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (p_valid),
        .clr       (last_clr),
        .p         (p),
        .acc       (acc),
        .acc_valid (acc_valid),
        .acc_sat   (acc_sat)
    );

endmodule

// File: tb/tb_feedforward_mul_pipe_mac.sv
// Bench for feedforward_mul_pipe_mac: four parameterisations driven side by side,
// checked every cycle against an arithmetic history model plus hand-computed literals.
module tb_feedforward_mul_pipe_mac;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic        in_valid = 1'b0;
    logic        acc_clr = 1'b0;
    logic [6:0]  a = '0;
    logic [31:0] b = '0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;

    logic signed [38:0] p0;  logic pv0, ovf0; logic signed [47:0] acc0; logic av0, sat0;
    logic signed [7:0]  p1;  logic pv1, ovf1; logic signed [47:0] acc1; logic av1, sat1;
    logic signed [38:0] p2;  logic pv2, ovf2; logic signed [39:0] acc2; logic av2, sat2;
    logic signed [38:0] p3;  logic pv3, ovf3; logic signed [38:0] acc3; logic av3, sat3;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    feedforward_mul_pipe_mac d0 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .a(a), .b(b), .acc_clr(acc_clr),
        .p(p0), .p_valid(pv0), .p_ovf(ovf0), .acc(acc0), .acc_valid(av0), .acc_sat(sat0));

    feedforward_mul_pipe_mac #(.A_W(8), .B_W(8), .A_SIGNED(1), .B_SIGNED(1), .P_W(8)) d1 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .a(a8), .b(b8), .acc_clr(acc_clr),
        .p(p1), .p_valid(pv1), .p_ovf(ovf1), .acc(acc1), .acc_valid(av1), .acc_sat(sat1));

    feedforward_mul_pipe_mac #(.ACC_W(40), .STAGES(4)) d2 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .a(a), .b(b), .acc_clr(acc_clr),
        .p(p2), .p_valid(pv2), .p_ovf(ovf2), .acc(acc2), .acc_valid(av2), .acc_sat(sat2));

    feedforward_mul_pipe_mac #(.ACC_W(39), .P_W(39), .STAGES(2)) d3 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .a(a), .b(b), .acc_clr(acc_clr),
        .p(p3), .p_valid(pv3), .p_ovf(ovf3), .acc(acc3), .acc_valid(av3), .acc_sat(sat3));

    // History of every operand pair accepted on a ce edge since the last reset.
    int          edge_cnt = 0;
    logic        hist_v   [0:2047];
    logic        hist_clr [0:2047];
    logic [6:0]  hist_a   [0:2047];
    logic [31:0] hist_b   [0:2047];
    logic [7:0]  hist_a8  [0:2047];
    logic [7:0]  hist_b8  [0:2047];

    // Record accepted inputs; reset empties the history.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cnt <= 0;
        end else if (ce && edge_cnt < 2040) begin
            hist_v[edge_cnt+1]   <= in_valid;
            hist_clr[edge_cnt+1] <= acc_clr;
            hist_a[edge_cnt+1]   <= a;
            hist_b[edge_cnt+1]   <= b;
            hist_a8[edge_cnt+1]  <= a8;
            hist_b8[edge_cnt+1]  <= b8;
            edge_cnt             <= edge_cnt + 1;
        end
    end

    function automatic int pw_of(input int s);
        return (s == 1) ? 8 : 39;
    endfunction

    function automatic int stg_of(input int s);
        case (s)
            2:       return 4;
            3:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int accw_of(input int s);
        case (s)
            2:       return 40;
            3:       return 39;
            default: return 48;
        endcase
    endfunction

    function automatic longint full_prod(input int s, input int k);
        if (s == 1) begin
            return longint'($signed(hist_a8[k])) * longint'($signed(hist_b8[k]));
        end
        return longint'(hist_a[k]) * longint'($signed(hist_b[k]));
    endfunction

    function automatic longint trunc_s(input longint x, input int w);
        longint m;
        m = x & ((longint'(1) << w) - 1);
        if (m[w-1]) begin
            m = m - (longint'(1) << w);
        end
        return m;
    endfunction

    task automatic compute_model(input int s, output longint e_pv, output longint e_p,
                                 output longint e_ovf, output longint e_acc,
                                 output longint e_av, output longint e_sat);
        int     k_out;
        longint fp, pv_val, sum, amax, amin, acc_m, sat_m;
        k_out = edge_cnt - stg_of(s) + 1;
        amax  = (longint'(1) << (accw_of(s) - 1)) - 1;
        amin  = -(longint'(1) << (accw_of(s) - 1));
        acc_m = 0; sat_m = 0; e_p = 0; e_ovf = 0;
        for (int k = 1; k <= k_out; k++) begin
            if (hist_v[k]) begin
                fp     = full_prod(s, k);
                pv_val = trunc_s(fp, pw_of(s));
                e_p    = pv_val;
                e_ovf  = (pv_val != fp) ? 1 : 0;
                if (k < k_out) begin
                    if (hist_clr[k]) begin
                        acc_m = pv_val;
                        sat_m = 0;
                    end else begin
                        sum = acc_m + pv_val;
                        if (sum > amax) begin
                            sum = amax; sat_m = 1;
                        end else if (sum < amin) begin
                            sum = amin; sat_m = 1;
                        end
                        acc_m = sum;
                    end
                end
            end
        end
        e_pv  = (k_out >= 1 && hist_v[k_out]) ? 1 : 0;
        e_av  = (k_out >= 2 && hist_v[k_out-1]) ? 1 : 0;
        e_acc = acc_m;
        e_sat = sat_m;
    endtask

    task automatic get_dut(input int s, output longint o_pv, output longint o_p,
                           output longint o_ovf, output longint o_acc,
                           output longint o_av, output longint o_sat);
        case (s)
            0: begin o_pv = longint'(pv0); o_p = longint'(p0); o_ovf = longint'(ovf0);
                     o_acc = longint'(acc0); o_av = longint'(av0); o_sat = longint'(sat0); end
            1: begin o_pv = longint'(pv1); o_p = longint'(p1); o_ovf = longint'(ovf1);
                     o_acc = longint'(acc1); o_av = longint'(av1); o_sat = longint'(sat1); end
            2: begin o_pv = longint'(pv2); o_p = longint'(p2); o_ovf = longint'(ovf2);
                     o_acc = longint'(acc2); o_av = longint'(av2); o_sat = longint'(sat2); end
            default: begin o_pv = longint'(pv3); o_p = longint'(p3); o_ovf = longint'(ovf3);
                     o_acc = longint'(acc3); o_av = longint'(av3); o_sat = longint'(sat3); end
        endcase
    endtask

    task automatic checkOutput(input string name, input longint got, input longint want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("[TB] FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
        end
    endtask

    // Compare every instance against the model on each falling edge.
    always @(negedge clk) begin
        longint e_pv, e_p, e_ovf, e_acc, e_av, e_sat;
        longint o_pv, o_p, o_ovf, o_acc, o_av, o_sat;
        for (int s = 0; s < 4; s++) begin
            compute_model(s, e_pv, e_p, e_ovf, e_acc, e_av, e_sat);
            get_dut(s, o_pv, o_p, o_ovf, o_acc, o_av, o_sat);
            checkOutput($sformatf("m%0d_p_valid", s), o_pv, e_pv);
            checkOutput($sformatf("m%0d_p", s), o_p, e_p);
            checkOutput($sformatf("m%0d_p_ovf", s), o_ovf, e_ovf);
            checkOutput($sformatf("m%0d_acc", s), o_acc, e_acc);
            checkOutput($sformatf("m%0d_acc_valid", s), o_av, e_av);
            checkOutput($sformatf("m%0d_acc_sat", s), o_sat, e_sat);
        end
    end

    task automatic applyStimulus(input logic v, input logic clr, input logic [6:0] av,
                                 input logic [31:0] bv, input logic [7:0] a8v, input logic [7:0] b8v);
        @(negedge clk);
        in_valid = v;
        acc_clr  = clr;
        a        = av;
        b        = bv;
        a8       = a8v;
        b8       = b8v;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 7'd0, 32'd0, 8'd0, 8'd0);
    endtask

    longint acc_seen [0:15];
    int     n_seen;
    int     pv_count;

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("rst_p", longint'(p0), 0);
        checkOutput("rst_p_valid", longint'(pv0), 0);
        checkOutput("rst_acc", longint'(acc0), 0);
        checkOutput("rst_acc_sat", longint'(sat3), 0);
        reset = 1'b0;
        ce    = 1'b1;

        $display("[TB] case 1: basic latency");
        applyStimulus(1'b1, 1'b1, 7'd127, 32'hFFFF_FFFF, 8'd0, 8'd0);
        idle_cycles(2);
        checkOutput("t1_pv_early", longint'(pv0), 0);
        @(negedge clk);
        checkOutput("t1_pv", longint'(pv0), 1);
        checkOutput("t1_p", longint'(p0), -127);
        checkOutput("t1_ovf", longint'(ovf0), 0);
        @(negedge clk);
        checkOutput("t1_pv_drop", longint'(pv0), 0);
        checkOutput("t1_p_hold", longint'(p0), -127);
        checkOutput("t1_acc", longint'(acc0), -127);
        checkOutput("t1_acc_valid", longint'(av0), 1);
        idle_cycles(4);

        $display("[TB] case 2: clock enable toggling");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 4) checkOutput("t2_pv_early", longint'(pv0), 0);
            if (i == 5) begin
                checkOutput("t2_pv", longint'(pv0), 1);
                checkOutput("t2_p", longint'(p0), 15);
            end
            if (i == 6) checkOutput("t2_pv_frozen", longint'(pv0), 1);
            if (i == 7) begin
                checkOutput("t2_pv_gone", longint'(pv0), 0);
                checkOutput("t2_p_hold", longint'(p0), 15);
            end
            ce       = (i % 2 == 0);
            in_valid = (i == 0) || (i == 1);
            acc_clr  = 1'b0;
            a        = (i == 0) ? 7'd5 : 7'd9;
            b        = (i == 0) ? 32'd3 : 32'd9;
        end
        @(negedge clk);
        ce = 1'b1;
        in_valid = 1'b0;
        idle_cycles(4);

        $display("[TB] case 3: narrow signed truncation");
        applyStimulus(1'b1, 1'b0, 7'd0, 32'd0, 8'h80, 8'h80);
        applyStimulus(1'b1, 1'b0, 7'd0, 32'd0, 8'hFF, 8'hFF);
        idle_cycles(1);
        @(negedge clk);
        checkOutput("t3_p_ovf_case", longint'(p1), 0);
        checkOutput("t3_ovf_set", longint'(ovf1), 1);
        @(negedge clk);
        checkOutput("t3_p_one", longint'(p1), 1);
        checkOutput("t3_ovf_clear", longint'(ovf1), 0);
        idle_cycles(6);

        $display("[TB] case 4: accumulate stream");
        n_seen = 0;
        for (int j = 0; j < 11; j++) begin
            case (j)
                0: applyStimulus(1'b1, 1'b1, 7'd100, 32'd1, 8'd0, 8'd0);
                1: applyStimulus(1'b1, 1'b0, 7'd100, 32'd2, 8'd0, 8'd0);
                2: applyStimulus(1'b1, 1'b0, 7'd50, 32'hFFFF_FFFF, 8'd0, 8'd0);
                default: idle_cycles(1);
            endcase
            if (av2 && n_seen < 16) begin
                acc_seen[n_seen] = longint'(acc2);
                n_seen++;
            end
        end
        checkOutput("t4_pulses", longint'(n_seen), 3);
        checkOutput("t4_acc_first", acc_seen[0], 100);
        checkOutput("t4_acc_second", acc_seen[1], 300);
        checkOutput("t4_acc_third", acc_seen[2], 250);
        applyStimulus(1'b1, 1'b1, 7'd7, 32'd1, 8'd0, 8'd0);
        idle_cycles(6);
        checkOutput("t4_acc_clr", longint'(acc2), 7);

        $display("[TB] case 5: accumulator saturation");
        applyStimulus(1'b1, 1'b1, 7'd127, 32'h7FFF_FFFF, 8'd0, 8'd0);
        applyStimulus(1'b1, 1'b0, 7'd1, 32'h7FFF_FFFF, 8'd0, 8'd0);
        applyStimulus(1'b1, 1'b0, 7'd127, 32'd1, 8'd0, 8'd0);
        idle_cycles(4);
        checkOutput("t5_acc_max", longint'(acc3), 64'sd274877906943);
        checkOutput("t5_sat_none", longint'(sat3), 0);
        applyStimulus(1'b1, 1'b0, 7'd1, 32'd1, 8'd0, 8'd0);
        idle_cycles(4);
        checkOutput("t5_acc_clamp", longint'(acc3), 64'sd274877906943);
        checkOutput("t5_sat_set", longint'(sat3), 1);
        applyStimulus(1'b1, 1'b0, 7'd5, 32'hFFFF_FFFF, 8'd0, 8'd0);
        idle_cycles(4);
        checkOutput("t5_acc_after", longint'(acc3), 64'sd274877906938);
        checkOutput("t5_sat_sticky", longint'(sat3), 1);
        applyStimulus(1'b1, 1'b1, 7'd3, 32'd1, 8'd0, 8'd0);
        idle_cycles(4);
        checkOutput("t5_acc_clr", longint'(acc3), 3);
        checkOutput("t5_sat_clr", longint'(sat3), 0);
        applyStimulus(1'b1, 1'b1, 7'd127, 32'h8000_0000, 8'd0, 8'd0);
        applyStimulus(1'b1, 1'b0, 7'd127, 32'h8000_0000, 8'd0, 8'd0);
        applyStimulus(1'b1, 1'b0, 7'd127, 32'h8000_0000, 8'd0, 8'd0);
        idle_cycles(4);
        checkOutput("t5_acc_min", longint'(acc3), -64'sd274877906944);
        checkOutput("t5_sat_neg", longint'(sat3), 1);
        idle_cycles(2);

        $display("[TB] case 6: reset with products in flight");
        applyStimulus(1'b1, 1'b0, 7'd3, 32'd3, 8'd0, 8'd0);
        applyStimulus(1'b1, 1'b0, 7'd4, 32'd4, 8'd0, 8'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_p", longint'(p0), 0);
        checkOutput("t6_p_valid", longint'(pv0), 0);
        checkOutput("t6_acc", longint'(acc0), 0);
        checkOutput("t6_acc_sat", longint'(sat3), 0);
        checkOutput("t6_acc_valid", longint'(av0), 0);
        @(negedge clk);
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        @(negedge clk);
        reset    = 1'b0;
        pv_count = 0;
        repeat (6) begin
            @(negedge clk);
            if (pv0 || pv3) pv_count++;
        end
        checkOutput("t6_no_pulse", longint'(pv_count), 0);

        idle_cycles(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
